// File: rtl/demux_pkg.sv
// Shared types and sizes for the burst dispatcher and its round-robin picker.
// Channel count is fixed at 8, so the select is 3 bits wide.
package demux_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {IDLE, ARB, XFER} dispatch_state_e;
    typedef logic [NUM_CH-1:0] ch_mask_t;
endpackage

// File: rtl/demux_rr_pick.sv
// Rotating-priority picker: first set mask bit in order ptr+1, ptr+2, ..., ptr.
// Latency: combinational.
// Backpressure: none; found=0 when the mask is empty.
module demux_rr_pick
    import demux_pkg::*;
(
    input  ch_mask_t         mask,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] sel,
    output logic             found
);
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        // i == NUM_CH wraps back onto ptr itself, so a lone enabled channel is re-granted.
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!found && mask[ptr + SEL_W'(i)]) begin
                sel   = ptr + SEL_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_burst_dispatcher.sv
// Shares one upstream stream among 8 channels, granting whole bursts round-robin.
// Latency: first beat 2 cycles after valid in IDLE; 1 ARB bubble between bursts.
// Backpressure: ready_o follows the selected channel's ready; optional DEMUX_STALL_SKIP_EN abandons stuck grants.
module demux_burst_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int STALL_CYC = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] cfg_en_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic [NUM_CH-1:0] ch_valid_o,
    output logic [DATA_W-1:0] ch_data_o,
    input  logic [NUM_CH-1:0] ch_ready_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              busy_o,
    output logic              stall_skip_o
);
    localparam int               CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    dispatch_state_e  state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, pick_sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick_found, xfer, hs, burst_end, skip;

    demux_rr_pick u_pick (
        .mask  (cfg_en_i),
        .ptr   (ptr_q),
        .sel   (pick_sel),
        .found (pick_found)
    );

    assign xfer       = (state_q == XFER);
    assign ready_o    = xfer & ch_ready_i[sel_q];
    assign ch_valid_o = xfer ? (ch_mask_t'(valid_i) << sel_q) : '0;
    assign ch_data_o  = data_i;
    assign sel_o      = sel_q;
    assign busy_o     = (state_q != IDLE);
    assign hs         = valid_i & ready_o;
    assign burst_end  = hs & ((cnt_q == LAST_CNT) | last_i);

`ifdef DEMUX_STALL_SKIP_EN
    localparam int SC_W = $clog2(STALL_CYC + 1);

    logic [SC_W-1:0] stall_q;
    logic            stalling;

    // Only a grant that has not moved a single beat may be abandoned.
    assign stalling     = xfer && (cnt_q == '0) && valid_i && !ch_ready_i[sel_q];
    assign skip         = stalling && (stall_q == SC_W'(STALL_CYC - 1));
    assign stall_skip_o = skip;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (stalling && !skip) begin
            stall_q <= stall_q + SC_W'(1);
        end else begin
            stall_q <= '0;
        end
    end
`else
    assign skip         = 1'b0;
    // STALL_CYC has no effect here; any legal value keeps this output at 0.
    assign stall_skip_o = (STALL_CYC < 1);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i && (cfg_en_i != '0)) state_d = ARB;
            end
            ARB: begin
                if (pick_found) begin
                    sel_d   = pick_sel;
                    cnt_d   = '0;
                    state_d = XFER;
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (burst_end || skip) begin
                    ptr_d   = sel_q;
                    cnt_d   = '0;
                    state_d = ARB;
                end else if (hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_demux_burst_dispatcher.sv
// Directed bench for demux_burst_dispatcher; inputs change and outputs are sampled around the falling edge.
module tb_demux_burst_dispatcher;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;
    localparam int STALL_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        cfg_en;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;
    logic [7:0]        ch_valid;
    logic [DATA_W-1:0] ch_data;
    logic [7:0]        ch_ready;
    logic [2:0]        sel;
    logic              busy;
    logic              stall_skip;

    int n_chk  = 0;
    int n_pass = 0;

    demux_burst_dispatcher #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .STALL_CYC (STALL_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_en_i     (cfg_en),
        .valid_i      (valid),
        .data_i       (data),
        .last_i       (last),
        .ready_o      (ready),
        .ch_valid_o   (ch_valid),
        .ch_data_o    (ch_data),
        .ch_ready_i   (ch_ready),
        .sel_o        (sel),
        .busy_o       (busy),
        .stall_skip_o (stall_skip)
    );

    always #5 clk = ~clk;

    task automatic apply_reset;
        rst_n    = 1'b0;
        valid    = 1'b0;
        last     = 1'b0;
        cfg_en   = 8'h00;
        ch_ready = 8'h00;
        data     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b1; cfg_en = 8'hFF; ch_ready = 8'hFF; data = 8'h5A; last = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({busy, ready, sel, ch_valid, stall_skip} !== 14'h0)
            $display("FAIL reset_outputs: got %h want 0", {busy, ready, sel, ch_valid, stall_skip});
        else n_pass++;
        n_chk++;
        if (ch_data !== 8'h5A) $display("FAIL reset_data: got %h want 5a", ch_data);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_v;
        apply_reset();
        cfg_en = 8'hFF; ch_ready = 8'hFF; valid = 1'b1;
        #1;
        n_chk++;
        if ({busy, ready, ch_valid} !== 10'h0) $display("FAIL rr_idle: got %h want 0", {busy, ready, ch_valid});
        else n_pass++;
        @(negedge clk);
        for (int b = 0; b < 9; b++) begin
            #1;
            n_chk++;
            if ({busy, ready, ch_valid} !== {1'b1, 1'b0, 8'h00})
                $display("FAIL rr_arb b=%0d: got %h want 200", b, {busy, ready, ch_valid});
            else n_pass++;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                data  = 8'(b * 16 + k);
                exp_v = 8'h01 << (b % 8);
                #1;
                n_chk++;
                if ({busy, ready, sel, ch_valid, ch_data} !== {1'b1, 1'b1, 3'(b % 8), exp_v, data})
                    $display("FAIL rr_beat b=%0d k=%0d: got %h want %h", b, k,
                             {busy, ready, sel, ch_valid, ch_data}, {1'b1, 1'b1, 3'(b % 8), exp_v, data});
                else n_pass++;
                @(negedge clk);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_sparse_mask;
        logic [2:0] exp_sel;
        logic [7:0] exp_v;
        apply_reset();
        cfg_en = 8'b1000_0100; ch_ready = 8'hFF; valid = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            exp_sel = (g == 1) ? 3'd7 : 3'd2;
            exp_v   = 8'h01 << exp_sel;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                #1;
                n_chk++;
                if ({ready, sel, ch_valid} !== {1'b1, exp_sel, exp_v})
                    $display("FAIL sparse g=%0d k=%0d: got %h want %h", g, k, {ready, sel, ch_valid}, {1'b1, exp_sel, exp_v});
                else n_pass++;
                @(negedge clk);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_last_early;
        apply_reset();
        cfg_en = 8'b0100_1000; ch_ready = 8'hFF; valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            last = (k == 1);
            #1;
            n_chk++;
            if ({ready, sel, ch_valid} !== {1'b1, 3'd3, 8'h08})
                $display("FAIL last_ch3 k=%0d: got %h want %h", k, {ready, sel, ch_valid}, {1'b1, 3'd3, 8'h08});
            else n_pass++;
            @(negedge clk);
        end
        last = 1'b0;
        #1;
        n_chk++;
        if ({busy, ch_valid} !== {1'b1, 8'h00}) $display("FAIL last_arb: got %h want 100", {busy, ch_valid});
        else n_pass++;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++;
            if ({ready, sel, ch_valid} !== {1'b1, 3'd6, 8'h40})
                $display("FAIL last_ch6 k=%0d: got %h want %h", k, {ready, sel, ch_valid}, {1'b1, 3'd6, 8'h40});
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_chk++;
        if ({busy, ch_valid} !== {1'b1, 8'h00}) $display("FAIL last_arb2: got %h want 100", {busy, ch_valid});
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if (sel !== 3'd3) $display("FAIL last_regrant: got %0d want 3", sel);
        else n_pass++;
        valid = 1'b0;
    endtask

    task automatic test_backpressure;
        apply_reset();
        cfg_en = 8'hFF; ch_ready = 8'hFF; valid = 1'b1;
        repeat (2) @(negedge clk);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            ch_ready = 8'hFE;
            valid    = (c < 5);
            #1;
            n_chk++;
            if ({ready, sel, ch_valid} !== {1'b0, 3'd0, 7'h00, valid})
                $display("FAIL bp_stall c=%0d: got %h want %h", c, {ready, sel, ch_valid}, {1'b0, 3'd0, 7'h00, valid});
            else n_pass++;
            @(negedge clk);
        end
        ch_ready = 8'hFF; valid = 1'b0;
        #1;
        n_chk++;
        if ({ready, ch_valid} !== {1'b1, 8'h00}) $display("FAIL bp_novalid: got %h want 100", {ready, ch_valid});
        else n_pass++;
        @(negedge clk);
        valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_chk++;
            if ({ready, sel, ch_valid} !== {1'b1, 3'd0, 8'h01})
                $display("FAIL bp_resume k=%0d: got %h want %h", k, {ready, sel, ch_valid}, {1'b1, 3'd0, 8'h01});
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_chk++;
        if ({busy, ready, ch_valid} !== {1'b1, 1'b0, 8'h00}) $display("FAIL bp_arb: got %h want 200", {busy, ready, ch_valid});
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if (sel !== 3'd1) $display("FAIL bp_next: got %0d want 1", sel);
        else n_pass++;
        valid = 1'b0;
    endtask

    task automatic test_mask_off;
        apply_reset();
        cfg_en = 8'b0010_0000; ch_ready = 8'hFF; valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k == 1) cfg_en = 8'h00;
            #1;
            n_chk++;
            if ({ready, sel, ch_valid} !== {1'b1, 3'd5, 8'h20})
                $display("FAIL moff_beat k=%0d: got %h want %h", k, {ready, sel, ch_valid}, {1'b1, 3'd5, 8'h20});
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_chk++;
        if ({busy, ch_valid} !== {1'b1, 8'h00}) $display("FAIL moff_arb: got %h want 100", {busy, ch_valid});
        else n_pass++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if ({busy, ready, sel, ch_valid} !== {1'b0, 1'b0, 3'd5, 8'h00})
                $display("FAIL moff_idle c=%0d: got %h want %h", c, {busy, ready, sel, ch_valid}, {1'b0, 1'b0, 3'd5, 8'h00});
            else n_pass++;
        end
        valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        apply_reset();
        cfg_en = 8'hFF; ch_ready = 8'hFF; valid = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        n_chk++;
        if ({sel, ch_valid} !== {3'd1, 8'h02}) $display("FAIL rmid_pre: got %h want 102", {sel, ch_valid});
        else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, ready, sel, ch_valid, stall_skip} !== 14'h0)
            $display("FAIL rmid_async: got %h want 0", {busy, ready, sel, ch_valid, stall_skip});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_chk++;
        if ({busy, ch_valid} !== {1'b1, 8'h00}) $display("FAIL rmid_arb: got %h want 100", {busy, ch_valid});
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if ({sel, ch_valid} !== {3'd0, 8'h01}) $display("FAIL rmid_regrant: got %h want 001", {sel, ch_valid});
        else n_pass++;
        valid = 1'b0;
    endtask

`ifdef DEMUX_STALL_SKIP_EN
    task automatic test_stall_skip;
        apply_reset();
        cfg_en = 8'b0000_0110; ch_ready = 8'hFD; valid = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 1; c <= STALL_CYC; c++) begin
            #1;
            n_chk++;
            if ({stall_skip, ready, sel} !== {(c == STALL_CYC), 1'b0, 3'd1})
                $display("FAIL skip_cyc c=%0d: got %h want %h", c, {stall_skip, ready, sel}, {(c == STALL_CYC), 1'b0, 3'd1});
            else n_pass++;
            @(negedge clk);
        end
        #1;
        n_chk++;
        if ({stall_skip, busy, ch_valid} !== {1'b0, 1'b1, 8'h00}) $display("FAIL skip_arb: got %h want 100", {stall_skip, busy, ch_valid});
        else n_pass++;
        @(negedge clk);
        #1;
        n_chk++;
        if ({ready, sel, ch_valid} !== {1'b1, 3'd2, 8'h04}) $display("FAIL skip_next: got %h want %h", {ready, sel, ch_valid}, {1'b1, 3'd2, 8'h04});
        else n_pass++;
        valid = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0; valid = 1'b0; last = 1'b0; cfg_en = 8'h00; ch_ready = 8'h00; data = '0;
        test_reset();
        test_round_robin();
        test_sparse_mask();
        test_last_early();
        test_backpressure();
        test_mask_off();
        test_reset_mid_burst();
`ifdef DEMUX_STALL_SKIP_EN
        test_stall_skip();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
